// File: rtl/rx_udp_parser.sv
// rx_udp_parser: reassembles MAC receive nibbles into bytes, filters IPv4/UDP
// frames addressed to this node and streams the UDP payload with frame markers.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line idle, waiting for the first nibble of a frame
// HDR     | checking/capturing Ethernet, IPv4 and UDP header bytes 0-41
// PAYLOAD | emitting payload bytes until remain reaches 0, then padding
// DROP    | frame rejected, discarding until the line goes idle
module rx_udp_parser #(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter logic [31:0] IP_ADDR  = 32'hC0A8_0002,
  parameter logic [15:0] UDP_PORT = 16'd7777
) (
  input  logic        clk_rx,
  input  logic        rst_n,
  input  logic        rx_vld,
  input  logic        rx_eof,
  input  logic [3:0]  rx_dat,
  output logic        pay_vld,
  output logic [7:0]  pay_dat,
  output logic        pay_sof,
  output logic        pay_eof,
  output logic        pay_err,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] src_port
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]  match_q, match_d;      // {still broadcast, still unicast}
  logic [47:0] sh_mac_q, sh_mac_d;
  logic [31:0] sh_ip_q, sh_ip_d;
  logic [15:0] sh_port_q, sh_port_d;
  logic [15:0] len_q, len_d;
  logic [15:0] remain_q, remain_d;
  logic        first_q, first_d;
  logic        pay_vld_q, pay_vld_d;
  logic [7:0]  pay_dat_q, pay_dat_d;
  logic        pay_sof_q, pay_sof_d;
  logic        pay_eof_q, pay_eof_d;
  logic        pay_err_q, pay_err_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;

  logic [7:0]  cur_byte;
  logic [7:0]  mac_exp;
  logic [7:0]  hdr_exp;
  logic        hdr_chk;

  assign cur_byte = {rx_dat, low_q};

  // Expected local MAC byte for header bytes 0-5
  always_comb begin
    mac_exp = 8'h00;
    case (byte_cnt_q[2:0])
      3'd0:    mac_exp = MAC_ADDR[47:40];
      3'd1:    mac_exp = MAC_ADDR[39:32];
      3'd2:    mac_exp = MAC_ADDR[31:24];
      3'd3:    mac_exp = MAC_ADDR[23:16];
      3'd4:    mac_exp = MAC_ADDR[15:8];
      3'd5:    mac_exp = MAC_ADDR[7:0];
      default: mac_exp = 8'h00;
    endcase
  end

  // Fixed-value header bytes: ethertype, version/IHL, protocol, dst IP, dst port
  always_comb begin
    hdr_chk = 1'b1;
    hdr_exp = 8'h00;
    case (byte_cnt_q)
      11'd12:  hdr_exp = 8'h08;
      11'd13:  hdr_exp = 8'h00;
      11'd14:  hdr_exp = 8'h45;
      11'd23:  hdr_exp = 8'h11;
      11'd30:  hdr_exp = IP_ADDR[31:24];
      11'd31:  hdr_exp = IP_ADDR[23:16];
      11'd32:  hdr_exp = IP_ADDR[15:8];
      11'd33:  hdr_exp = IP_ADDR[7:0];
      11'd36:  hdr_exp = UDP_PORT[15:8];
      11'd37:  hdr_exp = UDP_PORT[7:0];
      default: hdr_chk = 1'b0;
    endcase
  end

  // Next-state logic: nibble assembly, header filter and payload emission
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    low_d      = low_q;
    byte_cnt_d = byte_cnt_q;
    match_d    = match_q;
    sh_mac_d   = sh_mac_q;
    sh_ip_d    = sh_ip_q;
    sh_port_d  = sh_port_q;
    len_d      = len_q;
    remain_d   = remain_q;
    first_d    = first_q;
    pay_vld_d  = 1'b0;
    pay_dat_d  = pay_dat_q;
    pay_sof_d  = 1'b0;
    pay_eof_d  = 1'b0;
    pay_err_d  = 1'b0;
    src_mac_d  = src_mac_q;
    src_ip_d   = src_ip_q;
    src_port_d = src_port_q;

    if (state_q == S_IDLE) begin
      // the starting nibble is the low half of destination MAC byte 0
      if (rx_vld && !rx_eof) begin
        state_d    = S_HDR;
        phase_d    = 1'b1;
        low_d      = rx_dat;
        byte_cnt_d = 11'd0;
        match_d    = 2'b11;
        first_d    = 1'b1;
      end
    end else if (rx_eof) begin
      state_d = S_IDLE;
      phase_d = 1'b0;
      if (state_q == S_PAYLOAD) begin
        pay_eof_d = 1'b1;
        pay_err_d = (remain_q != 16'd0);
      end
    end else if (rx_vld) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        low_d = rx_dat;
      end else begin
        if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
        case (state_q)
          S_HDR: begin
            if (byte_cnt_q < 11'd6) begin
              match_d = {match_q[1] & (cur_byte == 8'hFF),
                         match_q[0] & (cur_byte == mac_exp)};
              if (match_d == 2'b00) state_d = S_DROP;
            end
            if (byte_cnt_q >= 11'd6 && byte_cnt_q <= 11'd11)
              sh_mac_d = {sh_mac_q[39:0], cur_byte};
            if (byte_cnt_q >= 11'd26 && byte_cnt_q <= 11'd29)
              sh_ip_d = {sh_ip_q[23:0], cur_byte};
            if (byte_cnt_q >= 11'd34 && byte_cnt_q <= 11'd35)
              sh_port_d = {sh_port_q[7:0], cur_byte};
            if (byte_cnt_q >= 11'd38 && byte_cnt_q <= 11'd39)
              len_d = {len_q[7:0], cur_byte};
            if (hdr_chk && (cur_byte != hdr_exp)) state_d = S_DROP;
            if (byte_cnt_q == 11'd41) begin
              if (len_q < 16'd8) begin
                state_d = S_DROP;
              end else begin
                state_d    = S_PAYLOAD;
                remain_d   = len_q - 16'd8;
                src_mac_d  = sh_mac_q;
                src_ip_d   = sh_ip_q;
                src_port_d = sh_port_q;
              end
            end
          end
          S_PAYLOAD: begin
            // bytes past the UDP length are Ethernet padding
            if (remain_q != 16'd0) begin
              pay_vld_d = 1'b1;
              pay_dat_d = cur_byte;
              pay_sof_d = first_q;
              first_d   = 1'b0;
              remain_d  = remain_q - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and registered outputs; reset aborts any frame in progress
  always_ff @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      low_q      <= 4'h0;
      byte_cnt_q <= 11'd0;
      match_q    <= 2'b00;
      sh_mac_q   <= 48'h0;
      sh_ip_q    <= 32'h0;
      sh_port_q  <= 16'h0;
      len_q      <= 16'h0;
      remain_q   <= 16'h0;
      first_q    <= 1'b0;
      pay_vld_q  <= 1'b0;
      pay_dat_q  <= 8'h00;
      pay_sof_q  <= 1'b0;
      pay_eof_q  <= 1'b0;
      pay_err_q  <= 1'b0;
      src_mac_q  <= 48'h0;
      src_ip_q   <= 32'h0;
      src_port_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      byte_cnt_q <= byte_cnt_d;
      match_q    <= match_d;
      sh_mac_q   <= sh_mac_d;
      sh_ip_q    <= sh_ip_d;
      sh_port_q  <= sh_port_d;
      len_q      <= len_d;
      remain_q   <= remain_d;
      first_q    <= first_d;
      pay_vld_q  <= pay_vld_d;
      pay_dat_q  <= pay_dat_d;
      pay_sof_q  <= pay_sof_d;
      pay_eof_q  <= pay_eof_d;
      pay_err_q  <= pay_err_d;
      src_mac_q  <= src_mac_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
    end
  end

  assign pay_vld  = pay_vld_q;
  assign pay_dat  = pay_dat_q;
  assign pay_sof  = pay_sof_q;
  assign pay_eof  = pay_eof_q;
  assign pay_err  = pay_err_q;
  assign src_mac  = src_mac_q;
  assign src_ip   = src_ip_q;
  assign src_port = src_port_q;

endmodule

// File: tb/tb_rx_udp_parser.sv
// tb_rx_udp_parser: drives directed Ethernet/IPv4/UDP frames as nibbles and
// checks every output cycle against a frame-level model of the parser.
module tb_rx_udp_parser;

  localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
  localparam logic [31:0] MY_IP     = 32'hC0A8_0002;
  localparam logic [47:0] PEER_MAC  = 48'h10_22_33_44_55_66;
  localparam logic [31:0] PEER_IP   = 32'hC0A8_0063;
  localparam logic [15:0] PEER_PORT = 16'd5000;

  typedef logic [7:0] byte_q_t [$];

  logic        clk_rx = 1'b0;
  logic        rst_n;
  logic        rx_vld;
  logic        rx_eof;
  logic [3:0]  rx_dat;
  logic        pay_vld;
  logic [7:0]  pay_dat;
  logic        pay_sof;
  logic        pay_eof;
  logic        pay_err;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;

  rx_udp_parser dut (
    .clk_rx   (clk_rx),
    .rst_n    (rst_n),
    .rx_vld   (rx_vld),
    .rx_eof   (rx_eof),
    .rx_dat   (rx_dat),
    .pay_vld  (pay_vld),
    .pay_dat  (pay_dat),
    .pay_sof  (pay_sof),
    .pay_eof  (pay_eof),
    .pay_err  (pay_err),
    .src_mac  (src_mac),
    .src_ip   (src_ip),
    .src_port (src_port)
  );

  always #5 clk_rx = ~clk_rx;

  int checks = 0;
  int errors = 0;

  // expected outputs for the cycle following the current input
  logic        exp_vld = 1'b0;
  logic        exp_sof = 1'b0;
  logic [7:0]  exp_dat = 8'h00;
  logic        exp_eof = 1'b0;
  logic        exp_err = 1'b0;
  logic [47:0] exp_mac = 48'h0;
  logic [31:0] exp_ip = 32'h0;
  logic [15:0] exp_port = 16'h0;

  logic [7:0]  got [$];
  int          eof_cnt = 0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // cycle-by-cycle compare against the model's expectations
  always @(negedge clk_rx) begin
    chk("pay_vld", {63'd0, pay_vld}, {63'd0, exp_vld});
    chk("pay_sof", {63'd0, pay_sof}, {63'd0, exp_sof});
    if (exp_vld) chk("pay_dat", {56'd0, pay_dat}, {56'd0, exp_dat});
    chk("pay_eof", {63'd0, pay_eof}, {63'd0, exp_eof});
    chk("pay_err", {63'd0, pay_err}, {63'd0, exp_err});
    chk("src_mac", {16'd0, src_mac}, {16'd0, exp_mac});
    chk("src_ip", {32'd0, src_ip}, {32'd0, exp_ip});
    chk("src_port", {48'd0, src_port}, {48'd0, exp_port});
    if (pay_vld === 1'b1) got.push_back(pay_dat);
    if (pay_eof === 1'b1) begin
      eof_cnt++;
      last_err = pay_err;
    end
  end

  task automatic clear_exp();
    exp_vld = 1'b0;
    exp_sof = 1'b0;
    exp_dat = 8'h00;
    exp_eof = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] etype,
                       input logic [15:0] dport, input logic [15:0] ulen,
                       input byte_q_t pay, input int pad_to, output byte_q_t b);
    logic [15:0] tlen;
    b = {};
    tlen = 16'd20 + ulen;
    for (int k = 5; k >= 0; k--) b.push_back(dst[8*k +: 8]);
    for (int k = 5; k >= 0; k--) b.push_back(PEER_MAC[8*k +: 8]);
    b.push_back(etype[15:8]); b.push_back(etype[7:0]);
    b.push_back(8'h45); b.push_back(8'h00);
    b.push_back(tlen[15:8]); b.push_back(tlen[7:0]);
    for (int k = 0; k < 4; k++) b.push_back(8'h00);
    b.push_back(8'h40); b.push_back(8'h11);
    b.push_back(8'h00); b.push_back(8'h00);
    for (int k = 3; k >= 0; k--) b.push_back(PEER_IP[8*k +: 8]);
    for (int k = 3; k >= 0; k--) b.push_back(MY_IP[8*k +: 8]);
    b.push_back(PEER_PORT[15:8]); b.push_back(PEER_PORT[7:0]);
    b.push_back(dport[15:8]); b.push_back(dport[7:0]);
    b.push_back(ulen[15:8]); b.push_back(ulen[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    foreach (pay[k]) b.push_back(pay[k]);
    while (b.size() < pad_to) b.push_back(8'h00);
  endtask

  // Model: decide acceptance from the whole frame, then drive its nibbles
  task automatic run_frame(input byte_q_t b, input int nnib, input bit do_eof, input bit gaps);
    int nb;
    int l;
    int npay;
    bit ok;
    logic [47:0] dst;
    nb = nnib / 2;
    l = 0;
    ok = (nb >= 42);
    if (ok) begin
      dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
      l = int'({b[38], b[39]});
      ok = (dst == MY_MAC || dst == 48'hFFFF_FFFF_FFFF) &&
           b[12] == 8'h08 && b[13] == 8'h00 && b[14] == 8'h45 && b[23] == 8'h11 &&
           {b[30], b[31], b[32], b[33]} == MY_IP &&
           {b[36], b[37]} == 16'd7777 && l >= 8;
    end
    npay = ok ? l - 8 : 0;
    for (int i = 0; i < nnib; i++) begin
      int j;
      logic [7:0] bv;
      j = i / 2;
      bv = (j < b.size()) ? b[j] : 8'h00;
      @(negedge clk_rx); #1;
      rx_vld = 1'b1;
      rx_eof = 1'b0;
      rx_dat = (i % 2 == 1) ? bv[7:4] : bv[3:0];
      clear_exp();
      exp_vld = ok && (i % 2 == 1) && j >= 42 && (j - 42) < npay;
      exp_sof = exp_vld && j == 42;
      exp_dat = exp_vld ? bv : 8'h00;
      if (ok && (i % 2 == 1) && j == 41) begin
        exp_mac  = {b[6], b[7], b[8], b[9], b[10], b[11]};
        exp_ip   = {b[26], b[27], b[28], b[29]};
        exp_port = {b[34], b[35]};
      end
      if (gaps) begin
        @(negedge clk_rx); #1;
        rx_vld = 1'b0;
        rx_eof = 1'b0;
        rx_dat = 4'hF;
        clear_exp();
      end
    end
    if (do_eof) begin
      @(negedge clk_rx); #1;
      rx_vld = 1'b0;
      rx_eof = 1'b1;
      rx_dat = 4'hA;
      clear_exp();
      exp_eof = ok;
      exp_err = ok && ((nb - 42) < npay);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk_rx); #1;
        clear_exp();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t b, p, rem;
    int g0, e0;
    rst_n  = 1'b1;
    rx_vld = 1'b0;
    rx_eof = 1'b1;
    rx_dat = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_pay_vld", {63'd0, pay_vld}, 64'd0);
    chk("reset_pay_eof", {63'd0, pay_eof}, 64'd0);
    chk("reset_src_mac", {16'd0, src_mac}, 64'd0);
    chk("reset_src_port", {48'd0, src_port}, 64'd0);
    @(negedge clk_rx); #1 rst_n = 1'b1;

    // valid unicast, L=12, DE AD BE EF
    p = {}; p.push_back(8'hDE); p.push_back(8'hAD); p.push_back(8'hBE); p.push_back(8'hEF);
    build(MY_MAC, 16'h0800, 16'd7777, 16'd12, p, 0, b);
    g0 = got.size(); e0 = eof_cnt;
    run_frame(b, 2 * b.size(), 1, 0);
    chk("f1_count", 64'(got.size() - g0), 64'd4);
    chk("f1_first", {56'd0, got[g0]}, 64'hDE);
    chk("f1_last", {56'd0, got[g0+3]}, 64'hEF);
    chk("f1_eof", 64'(eof_cnt - e0), 64'd1);
    chk("f1_err", {63'd0, last_err}, 64'd0);
    chk("f1_src_port", {48'd0, src_port}, 64'd5000);
    chk("f1_src_ip", {32'd0, src_ip}, 64'hC0A80063);

    // L=9, one byte then padding to 60 bytes
    p = {}; p.push_back(8'h55);
    build(MY_MAC, 16'h0800, 16'd7777, 16'd9, p, 60, b);
    g0 = got.size(); e0 = eof_cnt;
    run_frame(b, 2 * b.size(), 1, 0);
    chk("f2_count", 64'(got.size() - g0), 64'd1);
    chk("f2_byte", {56'd0, got[g0]}, 64'h55);
    chk("f2_err", {63'd0, last_err}, 64'd0);

    // wrong port, wrong ethertype, foreign unicast MAC
    p = {}; p.push_back(8'h01); p.push_back(8'h02);
    g0 = got.size(); e0 = eof_cnt;
    build(MY_MAC, 16'h0800, 16'd7778, 16'd10, p, 0, b);
    run_frame(b, 2 * b.size(), 1, 0);
    build(MY_MAC, 16'h0806, 16'd7777, 16'd10, p, 0, b);
    run_frame(b, 2 * b.size(), 1, 0);
    build(48'h02_00_00_00_00_02, 16'h0800, 16'd7777, 16'd10, p, 0, b);
    run_frame(b, 2 * b.size(), 1, 0);
    chk("drop_count", 64'(got.size() - g0), 64'd0);
    chk("drop_eof", 64'(eof_cnt - e0), 64'd0);

    // broadcast accepted, with idle gaps between nibbles
    g0 = got.size(); e0 = eof_cnt;
    build(48'hFFFF_FFFF_FFFF, 16'h0800, 16'd7777, 16'd10, p, 0, b);
    run_frame(b, 2 * b.size(), 1, 1);
    chk("bcast_count", 64'(got.size() - g0), 64'd2);
    chk("bcast_eof", 64'(eof_cnt - e0), 64'd1);

    // frame cut at 20 bytes, then L=100 cut after 10 payload bytes
    p = {};
    for (int k = 0; k < 92; k++) p.push_back(8'(k + 1));
    build(MY_MAC, 16'h0800, 16'd7777, 16'd100, p, 0, b);
    g0 = got.size(); e0 = eof_cnt;
    run_frame(b, 40, 1, 0);
    run_frame(b, 2 * 52, 1, 0);
    chk("trunc_count", 64'(got.size() - g0), 64'd10);
    chk("trunc_eof", 64'(eof_cnt - e0), 64'd1);
    chk("trunc_err", {63'd0, last_err}, 64'd1);

    // L=8 lone eof, L=4 dropped
    p = {};
    g0 = got.size(); e0 = eof_cnt;
    build(MY_MAC, 16'h0800, 16'd7777, 16'd8, p, 0, b);
    run_frame(b, 2 * b.size(), 1, 0);
    chk("zero_eof", 64'(eof_cnt - e0), 64'd1);
    chk("zero_err", {63'd0, last_err}, 64'd0);
    build(MY_MAC, 16'h0800, 16'd7777, 16'd4, p, 0, b);
    run_frame(b, 2 * b.size(), 1, 0);
    chk("short_eof", 64'(eof_cnt - e0), 64'd1);
    chk("short_count", 64'(got.size() - g0), 64'd0);

    // odd nibble count: third payload byte only half sent
    p = {}; p.push_back(8'h31); p.push_back(8'h42); p.push_back(8'h53);
    g0 = got.size(); e0 = eof_cnt;
    build(MY_MAC, 16'h0800, 16'd7777, 16'd11, p, 0, b);
    run_frame(b, 2 * 44 + 1, 1, 0);
    chk("odd_count", 64'(got.size() - g0), 64'd2);
    chk("odd_err", {63'd0, last_err}, 64'd1);

    // reset mid-payload, remainder rejected, then a normal frame
    p = {};
    for (int k = 1; k <= 8; k++) p.push_back(8'(k * 17));
    build(MY_MAC, 16'h0800, 16'd7777, 16'd16, p, 0, b);
    g0 = got.size(); e0 = eof_cnt;
    run_frame(b, 2 * 46, 0, 0);
    @(negedge clk_rx); #1;
    rst_n = 1'b0;
    rx_vld = 1'b0;
    rx_eof = 1'b0;
    clear_exp();
    exp_mac = 48'h0; exp_ip = 32'h0; exp_port = 16'h0;
    #1;
    chk("rst_pay_vld", {63'd0, pay_vld}, 64'd0);
    chk("rst_pay_dat", {56'd0, pay_dat}, 64'd0);
    chk("rst_src_ip", {32'd0, src_ip}, 64'd0);
    repeat (2) @(negedge clk_rx);
    #1 rst_n = 1'b1;
    rem = {};
    for (int k = 46; k < 50; k++) rem.push_back(b[k]);
    run_frame(rem, 2 * rem.size(), 1, 0);
    chk("rst_count", 64'(got.size() - g0), 64'd4);
    chk("rst_eof", 64'(eof_cnt - e0), 64'd0);
    p = {}; p.push_back(8'hDE); p.push_back(8'hAD); p.push_back(8'hBE); p.push_back(8'hEF);
    build(MY_MAC, 16'h0800, 16'd7777, 16'd12, p, 0, b);
    g0 = got.size(); e0 = eof_cnt;
    run_frame(b, 2 * b.size(), 1, 0);
    chk("post_rst_count", 64'(got.size() - g0), 64'd4);
    chk("post_rst_eof", 64'(eof_cnt - e0), 64'd1);
    chk("post_rst_src_mac", {16'd0, src_mac}, 64'h1022_3344_5566);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
